// File: rtl/register_file_sb.sv
// register_file_sb
// 2**N x M register file with two synchronous write ports, two combinational
// read ports (optional write-first bypass), a virtual PC register fed from
// R15, and a per-register busy scoreboard with a pending-register count.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   WE3/A3/WD3          primary write port (ALU/load writeback); clears busy
//   WE4/A4/WD4          secondary write port (base writeback); loses to WE3
//   A1/A2 -> RD1/RD2    combinational read ports
//   R15                 value returned for reads of PC_REG
//   ISSUE/AD            issued instruction that will later write AD
//   BUSY1/BUSY2         read address has a write still outstanding
//   PEND                number of registers currently busy
module register_file_sb #(
    parameter int N      = 4,
    parameter int M      = 32,
    parameter int PC_REG = 15,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         WE3,
    input  logic [N-1:0] A3,
    input  logic [M-1:0] WD3,
    input  logic         WE4,
    input  logic [N-1:0] A4,
    input  logic [M-1:0] WD4,
    input  logic [N-1:0] A1,
    input  logic [N-1:0] A2,
    input  logic [M-1:0] R15,
    input  logic         ISSUE,
    input  logic [N-1:0] AD,
    output logic [M-1:0] RD1,
    output logic [M-1:0] RD2,
    output logic         BUSY1,
    output logic         BUSY2,
    output logic [N:0]   PEND
);

    localparam int           NREG     = 1 << N;
    localparam logic [N-1:0] PC_ADDR  = N'(PC_REG);
    localparam logic         BYP      = (BYPASS != 0);
    localparam logic [N:0]   PEND_MAX = (N+1)'(NREG - 1);

    logic [M-1:0]    mem_reg [NREG];
    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [N:0]      pend_reg;
    logic [N:0]      pend_next;
    logic            pend_inc;
    logic            pend_dec;

    // Storage. WD3 is applied after WD4 so it wins on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (WE4 && A4 != PC_ADDR) begin
                mem_reg[A4] <= WD4;
            end
            if (WE3 && A3 != PC_ADDR) begin
                mem_reg[A3] <= WD3;
            end
        end
    end

    // Per-register scoreboard: a new issue overrides a same-cycle writeback,
    // since the issued instruction is a newer producer still in flight.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            assign set_vec[gi]   = ISSUE && (AD == N'(gi)) && (gi != PC_REG);
            assign clr_vec[gi]   = WE3 && (A3 == N'(gi));
            assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    // Count only real transitions of a busy bit.
    assign pend_inc = |(set_vec & ~busy_reg);
    assign pend_dec = |(clr_vec & busy_reg & ~set_vec);

    always_comb begin
        pend_next = pend_reg;
        if (pend_inc && !pend_dec && pend_reg != PEND_MAX) begin
            pend_next = pend_reg + 1'b1;
        end else if (pend_dec && !pend_inc && pend_reg != '0) begin
            pend_next = pend_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
            pend_reg <= '0;
        end else begin
            busy_reg <= busy_next;
            pend_reg <= pend_next;
        end
    end

    function automatic logic [M-1:0] read_port(input logic [N-1:0] addr);
        if (addr == PC_ADDR)             return R15;
        else if (BYP && WE3 && A3 == addr) return WD3;
        else if (BYP && WE4 && A4 == addr) return WD4;
        else                              return mem_reg[addr];
    endfunction

    function automatic logic busy_port(input logic [N-1:0] addr);
        return busy_reg[addr] && !(BYP && WE3 && A3 == addr) && (addr != PC_ADDR);
    endfunction

    assign RD1   = read_port(A1);
    assign RD2   = read_port(A2);
    assign BUSY1 = busy_port(A1);
    assign BUSY2 = busy_port(A2);
    assign PEND  = pend_reg;

endmodule
